// File: rtl/grey2rgb_unpack.sv
// Unpacks four 8-bit grey pixels per 32-bit word into a registered RGB pixel stream,
// with an optional per-word heat-map colouring.
module grey2rgb_unpack #(
  parameter bit HEAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        heat,
  output logic        word_ready,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        pix_valid,
  output logic        pix_last,
  input  logic        pix_ready
);

  logic [31:0] r_word;
  logic        r_heat;
  logic [1:0]  r_idx;
  logic        r_valid;
  logic        r_last;
  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic [7:0]  r_blue;

  logic        w_word_ready;
  logic        w_accept;
  logic        w_advance;
  logic [1:0]  w_next_idx;
  logic [7:0]  w_src_byte;
  logic        w_src_heat;
  logic [23:0] w_rgb;

  function automatic logic [7:0] f_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Four 64-wide ramps; the ramp term {g[5:0],00} is 4*(g - region base), never above 252.
  function automatic logic [23:0] f_colour(input logic [7:0] g, input logic hm);
    logic [7:0]  ramp;
    logic [23:0] rgb;
    ramp = {g[5:0], 2'b00};
    if (!hm) begin
      rgb = {g, g, g};
    end else begin
      case (g[7:6])
        2'b00:   rgb = {8'd0, 8'd0, ramp};
        2'b01:   rgb = {8'd0, ramp, 8'd255};
        2'b10:   rgb = {ramp, 8'd255, 8'd255 - ramp};
        default: rgb = {8'd255, 8'd255 - ramp, 8'd0};
      endcase
    end
    return rgb;
  endfunction

  assign w_word_ready = !r_valid || (r_valid && pix_ready && r_last);
  assign w_accept     = word_valid && w_word_ready;
  assign w_advance    = r_valid && pix_ready && !r_last;

  // Pick the pixel to present next: byte 0 of a fresh word, or the next stored byte.
  always_comb begin
    w_next_idx = 2'd0;
    w_src_byte = 8'd0;
    w_src_heat = 1'b0;
    if (w_accept) begin
      w_next_idx = 2'd0;
      w_src_byte = word_in[7:0];
      w_src_heat = heat && HEAT_EN;
    end else begin
      w_next_idx = r_idx + 2'd1;
      w_src_byte = f_byte(r_word, w_next_idx);
      w_src_heat = r_heat;
    end
  end

  assign w_rgb = f_colour(w_src_byte, w_src_heat);

  // Word latch, pixel index and registered colour outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= 32'd0;
      r_heat  <= 1'b0;
      r_idx   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_red   <= 8'd0;
      r_green <= 8'd0;
      r_blue  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_word <= word_in;
        r_heat <= heat && HEAT_EN;
      end
      if (w_accept || w_advance) begin
        r_idx   <= w_next_idx;
        r_valid <= 1'b1;
        r_last  <= (w_next_idx == 2'd3);
        r_red   <= w_rgb[23:16];
        r_green <= w_rgb[15:8];
        r_blue  <= w_rgb[7:0];
      end else if (r_valid && pix_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign word_ready = w_word_ready;
  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;
  assign pix_valid  = r_valid;
  assign pix_last   = r_last;

endmodule

// File: tb/tb_grey2rgb_unpack.sv
// Directed bench for grey2rgb_unpack: expected pixels are queued at word acceptance
// and compared at every pixel handshake; cycle-level behaviour is checked inline.
module tb_grey2rgb_unpack;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        heat;
  logic        word_ready;
  logic [7:0]  red, green, blue;
  logic        pix_valid, pix_last, pix_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [24:0] exp_q[$];

  grey2rgb_unpack #(.HEAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .heat(heat),
    .word_ready(word_ready), .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int g, input bit hm);
    int r, gg, b;
    if (!hm) begin r = g; gg = g; b = g; end
    else if (g < 64)  begin r = 0; gg = 0; b = 4 * g; end
    else if (g < 128) begin r = 0; gg = 4 * (g - 64); b = 255; end
    else if (g < 192) begin r = 4 * (g - 128); gg = 255; b = 255 - 4 * (g - 128); end
    else begin r = 255; gg = 255 - 4 * (g - 192); b = 0; end
    return {r[7:0], gg[7:0], b[7:0]};
  endfunction

  task automatic push_word(input logic [31:0] w, input bit hm);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({ref_rgb(int'(w[8*i +: 8]), hm), (i == 3)});
  endtask

  // Scoreboard: every handshaked pixel must match the oldest expected pixel.
  always @(negedge clk) begin
    if (!rst && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pixel", 32'd1, 32'd0);
      else chk("pixel", {7'd0, red, green, blue, pix_last}, {7'd0, exp_q.pop_front()});
    end
  end

  // Offer a word until accepted (bounded); returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] w, input bit hm);
    bit ok;
    ok = 1'b0;
    word_in = w; heat = hm; word_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (word_ready) begin ok = 1'b1; break; end
    end
    if (ok) push_word(w, hm);
    else chk("word_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    word_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; word_valid = 1'b1; word_in = 32'hDEADBEEF; heat = 1'b0; pix_ready = 1'b1;
    // Reset state, with a word offered that must not be accepted
    tick(2);
    @(negedge clk);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_pix_last", {31'd0, pix_last}, 32'd0);
    chk("rst_rgb", {8'd0, red, green, blue}, 32'd0);
    chk("rst_word_ready", {31'd0, word_ready}, 32'd1);
    @(posedge clk); #1;
    word_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("no_accept_in_rst", {31'd0, pix_valid}, 32'd0);
    tick(1);

    // Mono word: latency 1, four pixels, pix_last only on the fourth
    send_word(32'hC0804000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mono_valid", {31'd0, pix_valid}, 32'd1);
      chk("mono_last", {31'd0, pix_last}, {31'd0, (k == 3)});
    end
    @(negedge clk);
    chk("mono_drain", {31'd0, pix_valid}, 32'd0);
    tick(1);

    // Heat-map words: region mid-points and region boundaries
    send_word(32'hFFC0803F, 1'b1);
    tick(5);
    send_word(32'hBF7F4000, 1'b1);
    tick(5);

    // Back-to-back words: 8 pixels with no gap, word_ready only on pix_last
    word_valid = 1'b1; word_in = 32'h03020100; heat = 1'b0;
    @(negedge clk);
    chk("b2b_idle_ready", {31'd0, word_ready}, 32'd1);
    push_word(32'h03020100, 1'b0);
    @(posedge clk); #1;
    word_in = 32'hF0B07030; heat = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_valid_a", {31'd0, pix_valid}, 32'd1);
      chk("b2b_word_ready", {31'd0, word_ready}, {31'd0, (k == 3)});
      if (k == 3) push_word(32'hF0B07030, 1'b1);
    end
    @(posedge clk); #1;
    word_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_valid_b", {31'd0, pix_valid}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_drain", {31'd0, pix_valid}, 32'd0);
    tick(1);

    // Backpressure on pixel 2 for five cycles
    send_word(32'h33221100, 1'b0);
    tick(2);
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, pix_valid}, 32'd1);
      chk("bp_hold_rgb", {8'd0, red, green, blue}, 32'h00222222);
      chk("bp_hold_last", {31'd0, pix_last}, 32'd0);
      chk("bp_word_ready", {31'd0, word_ready}, 32'd0);
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_p2", {24'd0, red}, 32'h22);
    @(negedge clk);
    chk("bp_resume_p3", {23'd0, red, pix_last}, {23'd0, 8'h33, 1'b1});
    @(negedge clk);
    chk("bp_drain", {31'd0, pix_valid}, 32'd0);
    tick(1);

    // Asynchronous reset during pixel 1
    send_word(32'h44332211, 1'b0);
    tick(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("arst_rgb", {8'd0, red, green, blue}, 32'd0);
    chk("arst_pix_last", {31'd0, pix_last}, 32'd0);
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    tick(1);
    send_word(32'h88776655, 1'b0);
    @(negedge clk);
    chk("arst_restart_p0", {7'd0, red, green, blue, pix_last}, {7'd0, 24'h555555, 1'b0});
    tick(5);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/grey2rgb_unpack.md
GREY2RGB_UNPACK -- requirements
Module: grey2rgb_unpack

Interface
REQ-001 SHALL have parameter HEAT_EN, default 1, meaning: 1 = heat-map mode selectable via port heat; 0 = heat ignored, mono only.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port word_in  input  32  four packed 8-bit grey pixels; pixel 0 = [7:0], pixel 3 = [31:24].
REQ-005 SHALL have port word_valid  input  1  word_in and heat are valid.
REQ-006 SHALL have port heat  input  1  colour mode for the word, sampled at word acceptance; 0 = mono, 1 = heat map.
REQ-007 SHALL have port word_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have ports red, green, blue  output  8 each  registered RGB of the current pixel.
REQ-009 SHALL have port pix_valid  output  1  red/green/blue hold a valid pixel.
REQ-010 SHALL have port pix_last  output  1  current pixel is pixel 3 of its word.
REQ-011 SHALL have port pix_ready  input  1  downstream consumes the pixel when pix_valid && pix_ready.

Function
REQ-012 SHALL accept a word when word_valid && word_ready.
REQ-013 SHALL drive word_ready = !pix_valid || (pix_valid && pix_ready && pix_last), combinationally.
REQ-014 SHALL present pixel 0 of an accepted word on the outputs, with pix_valid=1, on the cycle after acceptance (latency 1).
REQ-015 SHALL, on each pixel handshake with pix_last=0, advance a 2-bit index and present the next pixel on the next cycle.
REQ-016 SHALL, on the pix_last handshake with a simultaneous word acceptance, present pixel 0 of the new word next cycle, with no bubble.
REQ-017 SHALL, on the pix_last handshake with no word accepted, clear pix_valid next cycle.
REQ-018 SHALL hold red/green/blue/pix_last stable while pix_valid && !pix_ready.
REQ-019 SHALL set pix_last = (index == 3).
REQ-020 SHALL latch word_in and heat into an internal register at acceptance; the input may change afterwards.
REQ-021 SHALL, in mono mode (heat=0 or HEAT_EN=0), output red = green = blue = g.
REQ-022 SHALL, in heat mode, map g as follows, using 8-bit arithmetic with no overflow (each term is at most 252):
- g 0-63: R=0, G=0, B=4g
- g 64-127: R=0, G=4(g-64), B=255
- g 128-191: R=4(g-128), G=255, B=255-4(g-128)
- g 192-255: R=255, G=255-4(g-192), B=0
REQ-023 SHALL register the colour mapping, so red/green/blue are flop outputs.
REQ-024 SHALL give word acceptance priority only through REQ-013; it SHALL never overwrite a pixel that has not been handshaked.
REQ-025 SHALL retain state indefinitely when word_valid=0 and pix_ready=0; no timeout.

Reset
REQ-026 SHALL, while rst=1, force pix_valid=0, pix_last=0, red=green=blue=0, index=0, and the word register to 0; word_ready is then 1.
REQ-027 SHALL, on reset mid-word, discard the remaining pixels; after release, the first output is pixel 0 of the next accepted word.
REQ-028 SHALL accept no word in a cycle where rst=1.

Verification
REQ-029 SHALL cover mono mode: word 0xC0804000, heat=0, pix_ready=1 -> on cycles +1..+4, RGB = 00/00/00, 40/40/40, 80/80/80, C0/C0/C0; pix_last only on the 4th; pix_valid=0 on cycle +5.
REQ-030 SHALL cover heat mode: word 0xFFC0803F, heat=1 -> (R,G,B) = (0,0,252), (0,255,255), (255,255,0), (255,3,0).
REQ-031 SHALL cover heat region boundaries: bytes 0x00, 0x40, 0x7F, 0xBF -> (0,0,0), (0,0,255), (0,252,255), (252,255,3).
REQ-032 SHALL cover back-to-back words with word_valid=1 and pix_ready=1 -> 8 consecutive valid pixels, no gap, word_ready high only on the pix_last cycles.
REQ-033 SHALL cover backpressure: pix_ready=0 for 5 cycles on pixel 2 -> outputs held, word_ready=0, then resume with pixel 2 and pixel 3.
REQ-034 SHALL cover async reset: rst pulsed mid-cycle during pixel 1 -> pix_valid=0 immediately, outputs 0; next word restarts at pixel 0.
